// File: rtl/mem_wb_forward_source.sv
// EX/MEM and MEM/WB pipeline registers with data-memory access and load formatting.
// Define MEM_STALL_EN to build the req/ready wait-state FSM, timeout counter and mem_err.
module mem_wb_forward_source #(
    parameter int          ADDR_W    = 10,
    parameter int          WAIT_MAX  = 15,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [63:0]       ex_ALU_result,
    input  logic [63:0]       ex_store_data,
    input  logic [31:0]       ex_Instruction,
    input  logic              ex_RegWrite,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic              ex_MemtoReg,
    input  logic              ex_mem_flush,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [63:0]       dmem_wdata,
    output logic [7:0]        dmem_wstrb,
    input  logic [63:0]       dmem_rdata,
    input  logic              dmem_ready,
    output logic [63:0]       EX_MEM_ALU_result,
    output logic [31:0]       EX_MEM_Instruction,
    output logic              EX_MEM_RegWrite,
    output logic [63:0]       MEM_WB_WriteBack,
    output logic [31:0]       MEM_WB_Instruction,
    output logic              MEM_WB_RegWrite,
    output logic              mem_stall,
    output logic              mem_err
);

    logic [63:0] ex_mem_sdata;
    logic        ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg;
    logic        access, abort;
    logic [2:0]  funct3, lane;
    logic [7:0]  strb_base;
    logic [63:0] rshift, load_fmt;

    assign access = ex_mem_memread | ex_mem_memwrite;
    assign funct3 = EX_MEM_Instruction[14:12];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            EX_MEM_ALU_result  <= '0;
            ex_mem_sdata       <= '0;
            EX_MEM_Instruction <= NOP_INSTR;
            EX_MEM_RegWrite    <= 1'b0;
            ex_mem_memread     <= 1'b0;
            ex_mem_memwrite    <= 1'b0;
            ex_mem_memtoreg    <= 1'b0;
        end else if (!mem_stall) begin
            if (ex_mem_flush) begin
                EX_MEM_ALU_result  <= '0;
                ex_mem_sdata       <= '0;
                EX_MEM_Instruction <= NOP_INSTR;
                EX_MEM_RegWrite    <= 1'b0;
                ex_mem_memread     <= 1'b0;
                ex_mem_memwrite    <= 1'b0;
                ex_mem_memtoreg    <= 1'b0;
            end else begin
                EX_MEM_ALU_result  <= ex_ALU_result;
                ex_mem_sdata       <= ex_store_data;
                EX_MEM_Instruction <= ex_Instruction;
                // writes to x0 never reach the register file or the forwarding compare
                EX_MEM_RegWrite    <= ex_RegWrite && (ex_Instruction[11:7] != 5'd0);
                ex_mem_memread     <= ex_MemRead;
                ex_mem_memwrite    <= ex_MemWrite;
                ex_mem_memtoreg    <= ex_MemtoReg;
            end
        end
    end

    // Misaligned addresses snap down to the access size's natural alignment.
    always_comb begin
        lane      = EX_MEM_ALU_result[2:0];
        strb_base = 8'h01;
        case (funct3[1:0])
            2'd0: begin lane = EX_MEM_ALU_result[2:0];         strb_base = 8'h01; end
            2'd1: begin lane = {EX_MEM_ALU_result[2:1], 1'b0}; strb_base = 8'h03; end
            2'd2: begin lane = {EX_MEM_ALU_result[2], 2'b00};  strb_base = 8'h0F; end
            default: begin lane = 3'd0;                        strb_base = 8'hFF; end
        endcase
    end

    assign dmem_we    = ex_mem_memwrite;
    assign dmem_addr  = {EX_MEM_ALU_result[ADDR_W-1:3], 3'b000};
    assign dmem_wdata = ex_mem_sdata << {lane, 3'b000};
    assign dmem_wstrb = ex_mem_memwrite ? (strb_base << lane) : 8'h00;
    assign rshift     = dmem_rdata >> {lane, 3'b000};

    always_comb begin
        load_fmt = rshift;
        case (funct3)
            3'd0: load_fmt = {{56{rshift[7]}},  rshift[7:0]};
            3'd1: load_fmt = {{48{rshift[15]}}, rshift[15:0]};
            3'd2: load_fmt = {{32{rshift[31]}}, rshift[31:0]};
            3'd4: load_fmt = {56'd0, rshift[7:0]};
            3'd5: load_fmt = {48'd0, rshift[15:0]};
            3'd6: load_fmt = {32'd0, rshift[31:0]};
            default: load_fmt = rshift;
        endcase
    end

`ifdef MEM_STALL_EN
    localparam int CNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t         state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            mem_err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (abort) mem_err <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dmem_req  = 1'b0;
        mem_stall = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    dmem_req = 1'b1;
                    if (!dmem_ready) begin
                        mem_stall = 1'b1;
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            default: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CNT_MAX) begin
                    // timeout: let EX/MEM advance, drop the access into a MEM/WB bubble
                    abort     = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    cnt_nxt   = cnt + 1'b1;
                end
            end
        endcase
    end
`else
    logic unused_ready;
    assign unused_ready = dmem_ready;
    assign dmem_req     = access;
    assign mem_stall    = 1'b0;
    assign mem_err      = 1'b0;
    assign abort        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            MEM_WB_WriteBack   <= '0;
            MEM_WB_Instruction <= NOP_INSTR;
            MEM_WB_RegWrite    <= 1'b0;
        end else if (mem_stall || abort) begin
            MEM_WB_WriteBack   <= '0;
            MEM_WB_Instruction <= NOP_INSTR;
            MEM_WB_RegWrite    <= 1'b0;
        end else begin
            MEM_WB_WriteBack   <= ex_mem_memtoreg ? load_fmt : EX_MEM_ALU_result;
            MEM_WB_Instruction <= EX_MEM_Instruction;
            MEM_WB_RegWrite    <= EX_MEM_RegWrite;
        end
    end

endmodule

// File: tb/tb_mem_wb_forward_source.sv
// Directed-vector bench for mem_wb_forward_source; wait-state cases build only with MEM_STALL_EN.
module tb_mem_wb_forward_source;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [63:0] ex_ALU_result, ex_store_data;
    logic [31:0] ex_Instruction;
    logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_mem_flush;
    logic        dmem_req, dmem_we;
    logic [9:0]  dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wstrb;
    logic [63:0] dmem_rdata;
    logic        dmem_ready;
    logic [63:0] EX_MEM_ALU_result, MEM_WB_WriteBack;
    logic [31:0] EX_MEM_Instruction, MEM_WB_Instruction;
    logic        EX_MEM_RegWrite, MEM_WB_RegWrite, mem_stall, mem_err;

    int checks = 0;
    int errors = 0;
    localparam logic [31:0] NOP = 32'h00000013;

    mem_wb_forward_source dut (
        .clk(clk), .reset_n(reset_n),
        .ex_ALU_result(ex_ALU_result), .ex_store_data(ex_store_data),
        .ex_Instruction(ex_Instruction), .ex_RegWrite(ex_RegWrite),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg),
        .ex_mem_flush(ex_mem_flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .EX_MEM_ALU_result(EX_MEM_ALU_result), .EX_MEM_Instruction(EX_MEM_Instruction),
        .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .MEM_WB_WriteBack(MEM_WB_WriteBack), .MEM_WB_Instruction(MEM_WB_Instruction),
        .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .mem_stall(mem_stall), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_nop();
        ex_ALU_result  = '0;
        ex_store_data  = '0;
        ex_Instruction = NOP;
        ex_RegWrite    = 1'b0;
        ex_MemRead     = 1'b0;
        ex_MemWrite    = 1'b0;
        ex_MemtoReg    = 1'b0;
    endtask

    // drive one instruction into EX/MEM, then leave a NOP on the EX side
    task automatic issue(input logic [63:0] alu, input logic [63:0] sd, input logic [31:0] ins,
                         input logic rw, input logic mr, input logic mw, input logic m2r);
        ex_ALU_result  = alu;
        ex_store_data  = sd;
        ex_Instruction = ins;
        ex_RegWrite    = rw;
        ex_MemRead     = mr;
        ex_MemWrite    = mw;
        ex_MemtoReg    = m2r;
        step();
        ex_nop();
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
        return {17'd0, f3, rd, 7'h03};
    endfunction

    initial begin
        reset_n      = 1'b0;
        ex_mem_flush = 1'b0;
        dmem_rdata   = '0;
        dmem_ready   = 1'b1;
        ex_nop();
        step();
        step();
        chk("rst_exmem_alu", EX_MEM_ALU_result, 64'd0);
        chk("rst_exmem_ins", EX_MEM_Instruction, NOP);
        chk("rst_wb_val", MEM_WB_WriteBack, 64'd0);
        chk("rst_wb_ins", MEM_WB_Instruction, NOP);
        chk("rst_wb_rw", MEM_WB_RegWrite, 1'b0);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", mem_stall, 1'b0);
        chk("rst_err", mem_err, 1'b0);
        reset_n = 1'b1;

        // ALU op: EX/MEM at +1, MEM/WB at +2
        issue(64'h10, 64'd0, mk(3'd0, 5'd5), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_exmem_alu", EX_MEM_ALU_result, 64'h10);
        chk("t1_exmem_rw", EX_MEM_RegWrite, 1'b1);
        step();
        chk("t1_wb_val", MEM_WB_WriteBack, 64'h10);
        chk("t1_wb_rw", MEM_WB_RegWrite, 1'b1);
        chk("t1_wb_ins", MEM_WB_Instruction, mk(3'd0, 5'd5));

        // LB at byte lane 3, sign-extended
        issue(64'h3, 64'd0, mk(3'd0, 5'd6), 1'b1, 1'b1, 1'b0, 1'b1);
        dmem_rdata = 64'h0000_0000_8000_0000;
        chk("t2_req", dmem_req, 1'b1);
        chk("t2_we", dmem_we, 1'b0);
        chk("t2_addr", dmem_addr, 10'h000);
        chk("t2_stall", mem_stall, 1'b0);
        step();
        chk("t2_lb", MEM_WB_WriteBack, 64'hFFFF_FFFF_FFFF_FF80);

        // LHU at odd address 0x25 -> halfword lane 4, zero-extended
        issue(64'h25, 64'd0, mk(3'd5, 5'd6), 1'b1, 1'b1, 1'b0, 1'b1);
        dmem_rdata = 64'h0000_9876_0000_0000;
        chk("lhu_addr", dmem_addr, 10'h020);
        step();
        chk("lhu_val", MEM_WB_WriteBack, 64'h0000_0000_0000_9876);

        issue(64'h4, 64'd0, mk(3'd2, 5'd6), 1'b1, 1'b1, 1'b0, 1'b1);
        dmem_rdata = 64'h8765_4321_0000_0000;
        step();
        chk("lw_val", MEM_WB_WriteBack, 64'hFFFF_FFFF_8765_4321);

        issue(64'h8, 64'd0, mk(3'd6, 5'd6), 1'b1, 1'b1, 1'b0, 1'b1);
        dmem_rdata = 64'h0000_0000_8765_4321;
        step();
        chk("lwu_val", MEM_WB_WriteBack, 64'h0000_0000_8765_4321);

        issue(64'h8, 64'd0, mk(3'd3, 5'd6), 1'b1, 1'b1, 1'b0, 1'b1);
        dmem_rdata = 64'h0123_4567_89AB_CDEF;
        step();
        chk("ld_val", MEM_WB_WriteBack, 64'h0123_4567_89AB_CDEF);

        // stores
        issue(64'h1, 64'h5A, mk(3'd0, 5'd0), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sb_we", dmem_we, 1'b1);
        chk("sb_strb", dmem_wstrb, 8'h02);
        chk("sb_data", dmem_wdata, 64'h0000_0000_0000_5A00);
        step();
        issue(64'h7, 64'h1122_3344, mk(3'd2, 5'd0), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sw_mis_strb", dmem_wstrb, 8'hF0);
        chk("sw_mis_data", dmem_wdata, 64'h1122_3344_0000_0000);
        step();

`ifdef MEM_STALL_EN
        // SH with three wait states; flush during stall must be ignored
        dmem_ready = 1'b0;
        issue(64'h1E, 64'hABCD, mk(3'd1, 5'd0), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_strb", dmem_wstrb, 8'hC0);
        chk("t3_data", dmem_wdata[63:48], 64'hABCD);
        chk("t3_addr", dmem_addr, 10'h018);
        chk("t3_stall1", mem_stall, 1'b1);
        step();
        chk("t3_stall2", mem_stall, 1'b1);
        chk("t3_bubble", MEM_WB_Instruction, NOP);
        ex_Instruction = mk(3'd0, 5'd9);
        ex_RegWrite    = 1'b1;
        ex_mem_flush   = 1'b1;
        step();
        chk("t3_stall3", mem_stall, 1'b1);
        chk("t3_flush_ign", EX_MEM_Instruction, mk(3'd1, 5'd0));
        ex_mem_flush = 1'b0;
        ex_nop();
        dmem_ready = 1'b1;
        #1;
        chk("t3_stall_drop", mem_stall, 1'b0);
        step();
        chk("t3_wb_ins", MEM_WB_Instruction, mk(3'd1, 5'd0));
`else
        issue(64'h1E, 64'hABCD, mk(3'd1, 5'd0), 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_strb", dmem_wstrb, 8'hC0);
        chk("t3_data", dmem_wdata[63:48], 64'hABCD);
        chk("t3_addr", dmem_addr, 10'h018);
        chk("t3_nostall", mem_stall, 1'b0);
        step();
`endif

        // rd = x0 suppresses RegWrite; flush without stall inserts a NOP
        issue(64'h77, 64'd0, mk(3'd0, 5'd0), 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5_exmem_rw", EX_MEM_RegWrite, 1'b0);
        step();
        chk("t5_wb_rw", MEM_WB_RegWrite, 1'b0);
        chk("t5_wb_val", MEM_WB_WriteBack, 64'h77);
        ex_Instruction = mk(3'd0, 5'd5);
        ex_RegWrite    = 1'b1;
        ex_mem_flush   = 1'b1;
        step();
        ex_mem_flush = 1'b0;
        ex_nop();
        chk("t5_flush_ins", EX_MEM_Instruction, NOP);
        chk("t5_flush_rw", EX_MEM_RegWrite, 1'b0);

`ifdef MEM_STALL_EN
        // LW that never completes: timeout after 15 stall cycles
        begin
            int n;
            dmem_ready = 1'b0;
            issue(64'h10, 64'd0, mk(3'd2, 5'd8), 1'b1, 1'b1, 1'b0, 1'b1);
            ex_ALU_result  = 64'h99;
            ex_Instruction = mk(3'd0, 5'd7);
            ex_RegWrite    = 1'b1;
            n = 0;
            while (mem_stall && n < 40) begin
                n++;
                step();
            end
            chk("t4_stall_cycles", n, 15);
            chk("t4_err_pre", mem_err, 1'b0);
            step();
            chk("t4_err", mem_err, 1'b1);
            chk("t4_bubble", MEM_WB_Instruction, NOP);
            chk("t4_bubble_rw", MEM_WB_RegWrite, 1'b0);
            chk("t4_advance", EX_MEM_Instruction, mk(3'd0, 5'd7));
            ex_nop();
            dmem_ready = 1'b1;
            step();
            chk("t4_resume", MEM_WB_Instruction, mk(3'd0, 5'd7));
            chk("t4_sticky", mem_err, 1'b1);
        end
        dmem_ready = 1'b0;
`endif

        // reset in the middle of an access
        issue(64'h0, 64'd0, mk(3'd3, 5'd6), 1'b1, 1'b1, 1'b0, 1'b1);
        step();
        reset_n = 1'b0;
        step();
        reset_n    = 1'b1;
        dmem_ready = 1'b1;
        chk("t6_req", dmem_req, 1'b0);
        chk("t6_stall", mem_stall, 1'b0);
        chk("t6_err", mem_err, 1'b0);
        chk("t6_exmem_ins", EX_MEM_Instruction, NOP);
        chk("t6_wb_val", MEM_WB_WriteBack, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
